fixmul_pipe: RTL and testbench

FIXMUL_PIPE -- requirements
Module: fixmul_pipe

---
 rtl/fixpt_pkg.sv | 17 +
 rtl/fixpt_round_sat.sv | 46 ++++
 rtl/fixmul_pipe.sv | 88 ++++++++
 tb/tb_fixmul_pipe.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fixpt_pkg.sv
// Shared fixed-point constants for the signed IW.FW multiplier datapath.
package fixpt_pkg;

  localparam int unsigned IW_DEFAULT    = 2;
  localparam int unsigned FW_DEFAULT    = 16;

  localparam int unsigned ROUND_TRUNC   = 0;
  localparam int unsigned ROUND_HALF_UP = 1;

  localparam int unsigned SAT_WRAP      = 0;
  localparam int unsigned SAT_CLAMP     = 1;

  function automatic int unsigned word_width(input int unsigned iw, input int unsigned fw);
    return iw + fw;
  endfunction

endpackage

// File: rtl/fixpt_round_sat.sv
// Reduces a full-precision 2W-bit signed product to IW.FW with optional
// half-up rounding and saturation; overflow is flagged in both modes.
module fixpt_round_sat
  import fixpt_pkg::*;
#(
  parameter int unsigned IW    = IW_DEFAULT,
  parameter int unsigned FW    = FW_DEFAULT,
  parameter int unsigned ROUND = ROUND_TRUNC,
  parameter int unsigned SAT   = SAT_CLAMP,
  localparam int unsigned W    = word_width(IW, FW),
  localparam int unsigned PW   = 2 * W
) (
  input  logic [PW-1:0] prod,
  output logic [W-1:0]  p,
  output logic          ovf
);

  // One guard bit above the product so the rounding add cannot overflow.
  localparam int unsigned XW = PW + 1;
  localparam logic [XW-1:0] HALF = XW'(1) << (FW - 1);

  logic signed [XW-1:0] ext;
  logic signed [XW-1:0] sum;
  logic signed [XW-1:0] r;
  logic [XW-W:0]        hi;

  always_comb begin
    ext = $signed({prod[PW-1], prod});
    sum = ext;
    if (ROUND == ROUND_HALF_UP) begin
      sum = ext + $signed(HALF);
    end
    r = sum >>> FW;
  end

  // Result fits in W bits only if everything from bit W-1 upward is pure sign.
  always_comb begin
    hi  = r[XW-1:W-1];
    ovf = (|hi) & ~(&hi);
    p   = r[W-1:0];
    if ((SAT == SAT_CLAMP) && ovf) begin
      p = r[XW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/fixmul_pipe.sv
// Three-stage signed fixed-point multiplier with a global valid/ready stall
// and a sticky overflow flag.
module fixmul_pipe
  import fixpt_pkg::*;
#(
  parameter int unsigned IW    = IW_DEFAULT,
  parameter int unsigned FW    = FW_DEFAULT,
  parameter int unsigned ROUND = ROUND_TRUNC,
  parameter int unsigned SAT   = SAT_CLAMP,
  localparam int unsigned W    = word_width(IW, FW)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] p,
  output logic         ovf,
  output logic         ovf_sticky,
  input  logic         ovf_clr
);

  localparam int unsigned PW = 2 * W;

  logic                stall;
  logic                s1_valid;
  logic signed [W-1:0] s1_a;
  logic signed [W-1:0] s1_b;
  logic                s2_valid;
  logic [PW-1:0]       s2_prod;
  logic [PW-1:0]       prod_c;
  logic [W-1:0]        p_c;
  logic                ovf_c;

  // Whole pipe freezes while the output holds an unaccepted result.
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Operands sign-extend to full product width before the multiply.
  assign prod_c = PW'(s1_a) * PW'(s1_b);

  fixpt_round_sat #(
    .IW    (IW),
    .FW    (FW),
    .ROUND (ROUND),
    .SAT   (SAT)
  ) u_round_sat (
    .prod (s2_prod),
    .p    (p_c),
    .ovf  (ovf_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s2_valid   <= 1'b0;
      s2_prod    <= '0;
      out_valid  <= 1'b0;
      p          <= '0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      // Bubbles shift along with data; only a stall holds the stages.
      if (!stall) begin
        s1_valid  <= in_valid;
        s1_a      <= a;
        s1_b      <= b;
        s2_valid  <= s1_valid;
        s2_prod   <= prod_c;
        out_valid <= s2_valid;
        p         <= p_c;
        ovf       <= s2_valid && ovf_c;
      end
      // A delivered overflow wins over a coincident clear.
      if (out_valid && out_ready && ovf) begin
        ovf_sticky <= 1'b1;
      end else if (ovf_clr) begin
        ovf_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fixmul_pipe.sv
// Directed bench for fixmul_pipe across all four ROUND/SAT combinations.
module tb_fixmul_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [17:0] a;
  logic [17:0] b;
  logic        out_ready;
  logic        ovf_clr;

  logic [3:0]  in_ready;
  logic [3:0]  out_valid;
  logic [3:0]  ovf;
  logic [3:0]  ovf_sticky;
  logic [17:0] p [4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // 0: trunc/clamp  1: round/clamp  2: trunc/wrap  3: round/wrap
  fixmul_pipe #(.IW(2), .FW(16), .ROUND(0), .SAT(1)) u_ts (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]),
    .a(a), .b(b), .out_valid(out_valid[0]), .out_ready(out_ready),
    .p(p[0]), .ovf(ovf[0]), .ovf_sticky(ovf_sticky[0]), .ovf_clr(ovf_clr));
  fixmul_pipe #(.IW(2), .FW(16), .ROUND(1), .SAT(1)) u_rs (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]),
    .a(a), .b(b), .out_valid(out_valid[1]), .out_ready(out_ready),
    .p(p[1]), .ovf(ovf[1]), .ovf_sticky(ovf_sticky[1]), .ovf_clr(ovf_clr));
  fixmul_pipe #(.IW(2), .FW(16), .ROUND(0), .SAT(0)) u_tw (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[2]),
    .a(a), .b(b), .out_valid(out_valid[2]), .out_ready(out_ready),
    .p(p[2]), .ovf(ovf[2]), .ovf_sticky(ovf_sticky[2]), .ovf_clr(ovf_clr));
  fixmul_pipe #(.IW(2), .FW(16), .ROUND(1), .SAT(0)) u_rw (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[3]),
    .a(a), .b(b), .out_valid(out_valid[3]), .out_ready(out_ready),
    .p(p[3]), .ovf(ovf[3]), .ovf_sticky(ovf_sticky[3]), .ovf_clr(ovf_clr));

  typedef struct {
    logic [17:0] a;
    logic [17:0] b;
    logic [17:0] p_ts;
    logic [17:0] p_rs;
    logic [17:0] p_tw;
    logic [17:0] p_rw;
    logic        ovf;
  } vec_t;

  vec_t        vecs [12];
  logic [17:0] expq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] stream_a(input int i);
    return (i % 2 == 1) ? 18'h08000 : 18'h10000;
  endfunction

  function automatic logic [17:0] stream_b(input int i);
    return 18'(i * 32'h1234 + 32'h100);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] ex [4];
    logic [17:0] held;
    logic [17:0] e;
    int          sent;
    int          recv;
    int          stall_cyc;
    bit          have_held;

    vecs[0]  = '{18'h10000, 18'h0C000, 18'h0C000, 18'h0C000, 18'h0C000, 18'h0C000, 1'b0};
    vecs[1]  = '{18'h18000, 18'h18000, 18'h1FFFF, 18'h1FFFF, 18'h24000, 18'h24000, 1'b1};
    vecs[2]  = '{18'h20000, 18'h20000, 18'h1FFFF, 18'h1FFFF, 18'h00000, 18'h00000, 1'b1};
    vecs[3]  = '{18'h08000, 18'h38000, 18'h3C000, 18'h3C000, 18'h3C000, 18'h3C000, 1'b0};
    vecs[4]  = '{18'h00001, 18'h08000, 18'h00000, 18'h00001, 18'h00000, 18'h00001, 1'b0};
    vecs[5]  = '{18'h3FFFF, 18'h08000, 18'h3FFFF, 18'h00000, 18'h3FFFF, 18'h00000, 1'b0};
    vecs[6]  = '{18'h20000, 18'h10000, 18'h20000, 18'h20000, 18'h20000, 18'h20000, 1'b0};
    vecs[7]  = '{18'h1FFFF, 18'h1FFFF, 18'h1FFFF, 18'h1FFFF, 18'h3FFFC, 18'h3FFFC, 1'b1};
    vecs[8]  = '{18'h20000, 18'h1FFFF, 18'h20000, 18'h20000, 18'h00002, 18'h00002, 1'b1};
    vecs[9]  = '{18'h30000, 18'h08001, 18'h37FFF, 18'h37FFF, 18'h37FFF, 18'h37FFF, 1'b0};
    vecs[10] = '{18'h00003, 18'h08000, 18'h00001, 18'h00002, 18'h00001, 18'h00002, 1'b0};
    vecs[11] = '{18'h3FFFD, 18'h08000, 18'h3FFFE, 18'h3FFFF, 18'h3FFFE, 18'h3FFFF, 1'b0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;

    // Reset state while reset is still asserted.
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_out_valid%0d", k), 32'(out_valid[k]), 0);
      check($sformatf("rst_p%0d", k), 32'(p[k]), 0);
      check($sformatf("rst_in_ready%0d", k), 32'(in_ready[k]), 1);
    end
    check("rst_ovf", 32'(ovf[0]), 0);
    check("rst_sticky", 32'(ovf_sticky[0]), 0);
    reset = 1'b0;

    // Table: one operation each, checked exactly three edges after presentation.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      a        = vecs[i].a;
      b        = vecs[i].b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      if (i == 0) check("latency_early", 32'(out_valid[0]), 0);
      @(negedge clk);
      ex[0] = vecs[i].p_ts;
      ex[1] = vecs[i].p_rs;
      ex[2] = vecs[i].p_tw;
      ex[3] = vecs[i].p_rw;
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid[0]), 1);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("vec%0d_p%0d", i, k), 32'(p[k]), 32'(ex[k]));
      end
      check($sformatf("vec%0d_ovf_clamp", i), 32'(ovf[0]), 32'(vecs[i].ovf));
      check($sformatf("vec%0d_ovf_wrap", i), 32'(ovf[3]), 32'(vecs[i].ovf));
    end

    @(negedge clk);
    check("sticky_set_clamp", 32'(ovf_sticky[0]), 1);
    check("sticky_set_wrap", 32'(ovf_sticky[2]), 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("sticky_cleared", 32'(ovf_sticky[0]), 0);

    // Back-to-back stream with a four-cycle output stall.
    sent      = 0;
    recv      = 0;
    stall_cyc = 0;
    have_held = 1'b0;
    held      = '0;
    for (int cyc = 0; cyc < 80 && recv < 10; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 5 && cyc < 9);
      in_valid  = (sent < 10);
      a         = stream_a(sent);
      b         = stream_b(sent);
      #1;
      if (out_valid[0] && !out_ready) begin
        stall_cyc++;
        check("stall_in_ready", 32'(in_ready[0]), 0);
        if (have_held) check("stall_p_hold", 32'(p[0]), 32'(held));
        held      = p[0];
        have_held = 1'b1;
      end
      if (out_valid[0] && out_ready) begin
        if (expq.size() == 0) begin
          check("stream_extra_out", 32'(recv), 32'hFFFF_FFFF);
        end else begin
          e = expq.pop_front();
          check($sformatf("stream_p%0d", recv), 32'(p[0]), 32'(e));
        end
        recv++;
      end
      if (in_valid && in_ready[0]) begin
        e = (sent % 2 == 1) ? (stream_b(sent) >> 1) : stream_b(sent);
        expq.push_back(e);
        sent++;
      end
    end
    check("stream_recv", 32'(recv), 10);
    check("stream_sent", 32'(sent), 10);
    check("stream_stall_cycles", 32'(stall_cyc), 4);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);

    // Reset with three overflowing operations in flight and the head stalled.
    out_ready = 1'b0;
    a         = 18'h18000;
    b         = 18'h18000;
    in_valid  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("inflight_head_valid", 32'(out_valid[0]), 1);
    check("inflight_in_ready", 32'(in_ready[0]), 0);
    reset     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid[0]), 0);
    check("midrst_p", 32'(p[0]), 0);
    check("midrst_ovf", 32'(ovf[0]), 0);
    check("midrst_sticky", 32'(ovf_sticky[0]), 0);
    check("midrst_in_ready", 32'(in_ready[0]), 1);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("postrst_out_valid%0d", c), 32'(out_valid[0]), 0);
    end

    // Clear coincident with an overflow transfer leaves the flag set.
    a        = 18'h18000;
    b        = 18'h18000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("clrset_pre_sticky", 32'(ovf_sticky[0]), 0);
    check("clrset_ovf", 32'(ovf[0]), 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("clrset_sticky_held", 32'(ovf_sticky[0]), 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("clr_alone", 32'(ovf_sticky[0]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
